// File: rtl/input_loader_pkg.sv
// Shared constants and state encoding for the input loader and the layers it feeds.
package input_loader_pkg;

  localparam int unsigned NUM_PIXELS = 784;
  localparam int unsigned WORD_W     = 32;

  typedef enum logic {
    LOAD = 1'b0,
    HOLD = 1'b1
  } loader_state_e;

endpackage

// File: rtl/input_loader.sv
// Serial-to-parallel frame packer: collects one word per handshake into a flat
// vector and holds it for the first fully connected layer until it is taken.
module input_loader
  import input_loader_pkg::*;
#(
  parameter int unsigned NUM_INPUTS = NUM_PIXELS,
  parameter int unsigned DATA_W     = WORD_W
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [DATA_W-1:0]              in_data,
  input  logic                           in_last,
  output logic [NUM_INPUTS*DATA_W-1:0]   out_vector,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic                           frame_err,
  output logic [$clog2(NUM_INPUTS+1)-1:0] words_loaded
);

  localparam int unsigned CNT_W = $clog2(NUM_INPUTS + 1);
  localparam int unsigned VEC_W = NUM_INPUTS * DATA_W;
  localparam int unsigned IDX_W = $clog2(VEC_W);

  loader_state_e          state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   err_q, err_d;
  logic [VEC_W-1:0]       vec_q;
  logic                   wr_en;
  logic                   clr;
  logic                   last_slot;
  logic [IDX_W-1:0]       wr_base;

  assign last_slot = (cnt_q == CNT_W'(NUM_INPUTS - 1));
  assign wr_base   = IDX_W'(cnt_q) * IDX_W'(DATA_W);

  // Next-state, counter and error decode
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    wr_en   = 1'b0;
    clr     = 1'b0;
    unique case (state_q)
      LOAD: begin
        if (in_valid) begin
          wr_en = 1'b1;
          cnt_d = cnt_q + CNT_W'(1);
          if (in_last || last_slot) begin
            state_d = HOLD;
            // Error unless the marker lands exactly on the final slot
            err_d   = in_last ^ last_slot;
          end
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_d = LOAD;
          cnt_d   = '0;
          clr     = 1'b1;
        end
      end
      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= LOAD;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // Frame storage; cleared on release so early-terminated frames read zero in unused slots
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      vec_q <= '0;
    end else if (wr_en) begin
      vec_q[wr_base +: DATA_W] <= in_data;
    end
  end

  assign in_ready     = (state_q == LOAD);
  assign out_valid    = (state_q == HOLD);
  assign out_vector   = vec_q;
  assign frame_err    = err_q;
  assign words_loaded = cnt_q;

endmodule

// File: tb/tb_input_loader.sv
// Directed, table-driven bench for input_loader: frame packing, error flag,
// backpressure, sparse input and synchronous reset behaviour.
module tb_input_loader;
  import input_loader_pkg::*;

  localparam int unsigned N  = NUM_PIXELS;
  localparam int unsigned W  = WORD_W;
  localparam int unsigned CW = $clog2(N + 1);

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     in_data;
  logic             in_last;
  logic [N*W-1:0]   out_vector;
  logic             out_valid;
  logic             out_ready;
  logic             frame_err;
  logic [CW-1:0]    words_loaded;

  input_loader #(.NUM_INPUTS(N), .DATA_W(W)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .in_last      (in_last),
    .out_vector   (out_vector),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .frame_err    (frame_err),
    .words_loaded (words_loaded)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int kind;      // data pattern
    int nw;        // words driven
    int last_at;   // index carrying in_last, -1 for none
    bit gaps;      // random in_valid gaps
    int bp;        // backpressure cycles in HOLD
    int exp_wl;    // expected words_loaded
    bit exp_err;   // expected frame_err
  } rec_t;

  rec_t           tbl[7];
  int             n_vec;
  int             n_bad;
  logic [N*W-1:0] exp_vec;
  logic [N*W-1:0] zero_vec;

  function automatic logic [W-1:0] word_of(int kind, int i);
    case (kind)
      1:       return 32'hA5A5_0000 + W'(i);
      2:       return 32'hFFFF_FFFF - W'(i);
      default: return W'(i + 1);
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_vec(input string name, input logic [N*W-1:0] exp);
    n_vec++;
    if (out_vector !== exp) begin
      int k;
      n_bad++;
      k = 0;
      for (int i = 0; i < int'(N); i++) begin
        if (out_vector[i*W +: W] !== exp[i*W +: W]) begin
          k = i;
          break;
        end
      end
      $display("FAIL %s: slot %0d got %0h expected %0h", name, k,
               out_vector[k*W +: W], exp[k*W +: W]);
    end
  endtask

  task automatic build_exp(input int kind, input int nw);
    exp_vec = '0;
    for (int i = 0; i < nw; i++) exp_vec[i*W +: W] = word_of(kind, i);
  endtask

  // Drives nw words; gap cycles carry in_last=1 with in_valid=0, which must be ignored
  task automatic send_frame(input int kind, input int nw, input int last_at, input bit gaps);
    for (int i = 0; i < nw; i++) begin
      int t;
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          in_valid = 1'b0;
          in_last  = 1'b1;
          in_data  = 32'hDEAD_BEEF;
          @(posedge clk); #1;
        end
      end
      in_valid = 1'b1;
      in_data  = word_of(kind, i);
      in_last  = (i == last_at);
      t = 0;
      while (!in_ready && t < 50) begin
        @(posedge clk); #1;
        t++;
      end
      if (!in_ready) begin
        n_vec++;
        n_bad++;
        $display("FAIL accept_timeout: word %0d got in_ready 0 expected 1", i);
        break;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = '0;
  endtask

  task automatic run_rec(input int r);
    build_exp(tbl[r].kind, tbl[r].exp_wl);
    send_frame(tbl[r].kind, tbl[r].nw, tbl[r].last_at, tbl[r].gaps);
    chk($sformatf("r%0d_out_valid", r), 32'(out_valid), 32'd1);
    chk($sformatf("r%0d_in_ready", r), 32'(in_ready), 32'd0);
    chk($sformatf("r%0d_words_loaded", r), 32'(words_loaded), 32'(tbl[r].exp_wl));
    chk($sformatf("r%0d_frame_err", r), 32'(frame_err), 32'(tbl[r].exp_err));
    chk_vec($sformatf("r%0d_vector", r), exp_vec);
    for (int c = 0; c < tbl[r].bp; c++) begin
      in_valid = 1'b1;
      in_data  = $urandom;
      @(posedge clk); #1;
      chk($sformatf("r%0d_bp_in_ready", r), 32'(in_ready), 32'd0);
      chk_vec($sformatf("r%0d_bp_vector", r), exp_vec);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk($sformatf("r%0d_rel_in_ready", r), 32'(in_ready), 32'd1);
    chk($sformatf("r%0d_rel_out_valid", r), 32'(out_valid), 32'd0);
    chk($sformatf("r%0d_rel_words", r), 32'(words_loaded), 32'd0);
    chk($sformatf("r%0d_rel_err_held", r), 32'(frame_err), 32'(tbl[r].exp_err));
    chk_vec($sformatf("r%0d_rel_vector", r), zero_vec);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_words"}, 32'(words_loaded), 32'd0);
    chk({tag, "_frame_err"}, 32'(frame_err), 32'd0);
    chk_vec({tag, "_vector"}, zero_vec);
  endtask

  initial begin
    n_vec     = 0;
    n_bad     = 0;
    zero_vec  = '0;
    exp_vec   = '0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    out_ready = 1'b0;

    //          kind nw   last gaps bp  wl   err
    tbl[0] = '{0, 784, 783, 1'b0, 20, 784, 1'b0};
    tbl[1] = '{1, 10,  9,   1'b0, 0,  10,  1'b1};
    tbl[2] = '{0, 784, -1,  1'b0, 0,  784, 1'b1};
    tbl[3] = '{0, 784, 783, 1'b0, 0,  784, 1'b0};
    tbl[4] = '{0, 784, 783, 1'b1, 3,  784, 1'b0};
    tbl[5] = '{2, 1,   0,   1'b0, 0,  1,   1'b1};
    tbl[6] = '{2, 784, 783, 1'b1, 0,  784, 1'b0};

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk_reset_state("por");

    for (int r = 0; r < 7; r++) run_rec(r);

    // Reset partway through loading a frame
    send_frame(0, 300, -1, 1'b0);
    chk("mid_load_words", 32'(words_loaded), 32'd300);
    chk("mid_load_in_ready", 32'(in_ready), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk_reset_state("rst_load");
    run_rec(3);

    // Reset while holding a frame that carried an error
    build_exp(1, 10);
    send_frame(1, 10, 9, 1'b0);
    chk("pre_hold_rst_out_valid", 32'(out_valid), 32'd1);
    chk("pre_hold_rst_err", 32'(frame_err), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk_reset_state("rst_hold");
    run_rec(0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
